vga_palette_lut: RTL and testbench

Programmable, pipelined colour-palette lookup for the VGA graphics path. It maps a per-pixel colour index to separate R/G/B channel values and generalises the fixed 8-entry palette decoder in index width and channel width. It adds a runtime-writable palette, per-frame dimming and blank forcing. It sits between the pixel generator and the VGA DAC pins, and carries valid/blank sideband aligned to its latency.

---
 rtl/vga_palette_pkg.sv | 48 ++++
 rtl/vga_palette_lut_if.sv | 28 ++
 rtl/vga_palette_regs.sv | 54 +++++
 rtl/vga_palette_lut.sv | 87 ++++++++
 tb/tb_vga_palette_lut.sv | 207 ++++++++++++++++++++
 5 files changed

// File: rtl/vga_palette_pkg.sv
// Shared types, the default 8-entry palette and channel pack/align helpers
// for the VGA palette lookup.
package vga_palette_pkg;

  localparam int MAX_CW    = 16;
  localparam int DEF_DEPTH = 8;

  typedef logic [3*MAX_CW-1:0] wide_entry_t;
  typedef logic [MAX_CW-1:0]   wide_chan_t;

  typedef enum int {CH_R = 0, CH_G = 1, CH_B = 2} chan_e;

  // Packed {b, g, r}, 8 bits per channel.
  localparam logic [23:0] DEFAULT_PALETTE [DEF_DEPTH] = '{
    24'h000000, 24'h030326, 24'h0a0a46, 24'h38383a,
    24'h2d2621, 24'h000000, 24'h241211, 24'h645f57
  };

  function automatic wide_chan_t align_chan(input logic [7:0] c8, input int cw);
    wide_chan_t w;
    w = wide_chan_t'(c8);
    if (cw >= 8) return w << (cw - 8);
    else         return w >> (8 - cw);
  endfunction

  function automatic wide_chan_t get_chan(input wide_entry_t e, input int cw, input chan_e ch);
    wide_entry_t sh;
    wide_chan_t  mask;
    sh   = e >> (int'(ch) * cw);
    mask = '1;
    mask = mask >> (MAX_CW - cw);
    return sh[MAX_CW-1:0] & mask;
  endfunction

  function automatic wide_entry_t pack_entry(input wide_chan_t r, input wide_chan_t g,
                                             input wide_chan_t b, input int cw);
    return (wide_entry_t'(b) << (2 * cw)) | (wide_entry_t'(g) << cw) | wide_entry_t'(r);
  endfunction

  function automatic wide_entry_t default_entry(input int idx, input int cw);
    logic [23:0] d;
    if (idx >= DEF_DEPTH) return '0;
    d = DEFAULT_PALETTE[idx];
    return pack_entry(align_chan(d[7:0], cw), align_chan(d[15:8], cw),
                      align_chan(d[23:16], cw), cw);
  endfunction

endpackage

// File: rtl/vga_palette_lut_if.sv
// Pixel, palette-write and DAC-side signals of the palette lookup.
interface vga_palette_lut_if #(
  parameter int IDX_W   = 3,
  parameter int COLOR_W = 8
);
  logic [IDX_W-1:0]     pix_idx;
  logic                 pix_valid;
  logic                 blank;
  logic [1:0]           dim;
  logic                 wr_en;
  logic [IDX_W-1:0]     wr_addr;
  logic [3*COLOR_W-1:0] wr_data;
  logic [COLOR_W-1:0]   vga_r;
  logic [COLOR_W-1:0]   vga_g;
  logic [COLOR_W-1:0]   vga_b;
  logic                 valid_out;
  logic                 blank_out;

  modport master (
    output pix_idx, pix_valid, blank, dim, wr_en, wr_addr, wr_data,
    input  vga_r, vga_g, vga_b, valid_out, blank_out
  );

  modport slave (
    input  pix_idx, pix_valid, blank, dim, wr_en, wr_addr, wr_data,
    output vga_r, vga_g, vga_b, valid_out, blank_out
  );
endinterface

// File: rtl/vga_palette_regs.sv
// Writable palette held in flops, reset to the default table, with a
// write-first combinational read port.
module vga_palette_regs
  import vga_palette_pkg::*;
#(
  parameter int IDX_W   = 3,
  parameter int COLOR_W = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wr_en,
  input  logic [IDX_W-1:0]       wr_addr,
  input  logic [3*COLOR_W-1:0]   wr_data,
  input  logic [IDX_W-1:0]       rd_idx,
  output logic [3*COLOR_W-1:0]   rd_data
);
  localparam int DEPTH   = 2 ** IDX_W;
  localparam int ENTRY_W = 3 * COLOR_W;

  function automatic logic [DEPTH*ENTRY_W-1:0] build_reset();
    logic [DEPTH*ENTRY_W-1:0] flat;
    wide_entry_t              w;
    flat = '0;
    for (int i = 0; i < DEPTH; i++) begin
      w = default_entry(i, COLOR_W);
      flat[i*ENTRY_W +: ENTRY_W] = w[ENTRY_W-1:0];
    end
    return flat;
  endfunction

  localparam logic [DEPTH*ENTRY_W-1:0] RST_FLAT = build_reset();

  logic [ENTRY_W-1:0] pal_q [DEPTH];
  logic [ENTRY_W-1:0] pal_d [DEPTH];

  always_comb begin
    pal_d = pal_q;
    if (wr_en) pal_d[wr_addr] = wr_data;
  end

  // NOTE: every entry has an async reset value, so this stays a flop array
  // and the default palette is live straight out of reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) pal_q[i] <= RST_FLAT[i*ENTRY_W +: ENTRY_W];
    end else begin
      pal_q <= pal_d;
    end
  end

  // Same-cycle write to the looked-up entry bypasses the array.
  assign rd_data = (wr_en && (wr_addr == rd_idx)) ? wr_data : pal_q[rd_idx];

endmodule

// File: rtl/vga_palette_lut.sv
// Two-stage palette lookup: stage 1 captures the entry and sideband,
// stage 2 applies dimming and blanking before driving the DAC pins.
module vga_palette_lut
  import vga_palette_pkg::*;
#(
  parameter int IDX_W   = 3,
  parameter int COLOR_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  vga_palette_lut_if.slave bus
);
  localparam int ENTRY_W = 3 * COLOR_W;

  typedef struct packed {
    logic               valid;
    logic               blank;
    logic [1:0]         dim;
    logic [ENTRY_W-1:0] entry;
  } s1_t;

  typedef struct packed {
    logic               valid;
    logic               blank;
    logic [COLOR_W-1:0] r;
    logic [COLOR_W-1:0] g;
    logic [COLOR_W-1:0] b;
  } s2_t;

  logic [ENTRY_W-1:0] rd_entry;
  s1_t                s1_d, s1_q;
  s2_t                s2_d, s2_q;
  wide_entry_t        entry_w;
  wide_chan_t         ch_r, ch_g, ch_b;

  vga_palette_regs #(.IDX_W(IDX_W), .COLOR_W(COLOR_W)) u_regs (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (bus.wr_en),
    .wr_addr (bus.wr_addr),
    .wr_data (bus.wr_data),
    .rd_idx  (bus.pix_idx),
    .rd_data (rd_entry)
  );

  always_comb begin
    s1_d.valid = bus.pix_valid;
    s1_d.blank = bus.blank;
    s1_d.dim   = bus.dim;
    s1_d.entry = rd_entry;
  end

  // NOTE: everything driven here gets a value on every path first, so no
  // latch can be inferred.
  always_comb begin
    entry_w    = wide_entry_t'(s1_q.entry);
    ch_r       = get_chan(entry_w, COLOR_W, CH_R);
    ch_g       = get_chan(entry_w, COLOR_W, CH_G);
    ch_b       = get_chan(entry_w, COLOR_W, CH_B);
    s2_d       = '0;
    s2_d.valid = s1_q.valid;
    s2_d.blank = s1_q.blank;
    if (!s1_q.blank) begin
      s2_d.r = ch_r[COLOR_W-1:0] >> s1_q.dim;
      s2_d.g = ch_g[COLOR_W-1:0] >> s1_q.dim;
      s2_d.b = ch_b[COLOR_W-1:0] >> s1_q.dim;
    end
  end

  // NOTE: non-blocking assignments keep both stages sampling pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q <= '0;
      s2_q <= '0;
    end else begin
      s1_q <= s1_d;
      s2_q <= s2_d;
    end
  end

  assign bus.vga_r     = s2_q.r;
  assign bus.vga_g     = s2_q.g;
  assign bus.vga_b     = s2_q.b;
  assign bus.valid_out = s2_q.valid;
  assign bus.blank_out = s2_q.blank;

endmodule

// File: tb/tb_vga_palette_lut.sv
// Scoreboard bench for vga_palette_lut: default 3/8 instance plus a 4/10
// instance for the width sweep.
module tb_vga_palette_lut;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  vga_palette_lut_if #(.IDX_W(3), .COLOR_W(8))  bus_a ();
  vga_palette_lut_if #(.IDX_W(4), .COLOR_W(10)) bus_b ();

  vga_palette_lut #(.IDX_W(3), .COLOR_W(8))  dut_a (.clk(clk), .rst(rst), .bus(bus_a));
  vga_palette_lut #(.IDX_W(4), .COLOR_W(10)) dut_b (.clk(clk), .rst(rst), .bus(bus_b));

  typedef struct packed {
    logic [9:0] r;
    logic [9:0] g;
    logic [9:0] b;
    logic       blank;
  } exp_t;

  exp_t q_a[$];
  exp_t q_b[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  logic [23:0] def_tbl [8] = '{
    24'h000000, 24'h030326, 24'h0a0a46, 24'h38383a,
    24'h2d2621, 24'h000000, 24'h241211, 24'h645f57
  };
  logic [23:0] tbl_a [8];
  logic [29:0] mdl_b [16];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
  endtask

  // Monitor: pops one expectation per presented output.
  always @(negedge clk) begin
    if (!rst) begin
      if (bus_a.valid_out) begin
        exp_t e;
        if (q_a.size() == 0) check("a_unexpected_valid", 32'd1, 32'd0);
        else begin
          e = q_a.pop_front();
          check("a_r", 32'(bus_a.vga_r), 32'(e.r));
          check("a_g", 32'(bus_a.vga_g), 32'(e.g));
          check("a_b", 32'(bus_a.vga_b), 32'(e.b));
          check("a_blank", 32'(bus_a.blank_out), 32'(e.blank));
        end
      end
      if (bus_b.valid_out) begin
        exp_t e;
        if (q_b.size() == 0) check("b_unexpected_valid", 32'd1, 32'd0);
        else begin
          e = q_b.pop_front();
          check("b_r", 32'(bus_b.vga_r), 32'(e.r));
          check("b_g", 32'(bus_b.vga_g), 32'(e.g));
          check("b_b", 32'(bus_b.vga_b), 32'(e.b));
          check("b_blank", 32'(bus_b.blank_out), 32'(e.blank));
        end
      end
    end
  end

  task automatic drive_a(input logic [2:0] idx, input logic v, input logic bl, input logic [1:0] d,
                         input logic wen, input logic [2:0] wa, input logic [23:0] wd,
                         input logic [7:0] er, input logic [7:0] eg, input logic [7:0] eb);
    exp_t e;
    @(negedge clk);
    bus_a.pix_idx = idx; bus_a.pix_valid = v; bus_a.blank = bl; bus_a.dim = d;
    bus_a.wr_en = wen; bus_a.wr_addr = wa; bus_a.wr_data = wd;
    e.r = 10'(er); e.g = 10'(eg); e.b = 10'(eb); e.blank = bl;
    if (v) q_a.push_back(e);
  endtask

  task automatic drive_b(input logic [3:0] idx, input logic bl, input logic [1:0] d,
                         input logic wen, input logic [3:0] wa, input logic [29:0] wd,
                         input logic [9:0] er, input logic [9:0] eg, input logic [9:0] eb);
    exp_t e;
    @(negedge clk);
    bus_b.pix_idx = idx; bus_b.pix_valid = 1'b1; bus_b.blank = bl; bus_b.dim = d;
    bus_b.wr_en = wen; bus_b.wr_addr = wa; bus_b.wr_data = wd;
    e.r = er; e.g = eg; e.b = eb; e.blank = bl;
    q_b.push_back(e);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      bus_a.pix_valid = 1'b0; bus_a.wr_en = 1'b0;
      bus_b.pix_valid = 1'b0; bus_b.wr_en = 1'b0;
    end
  endtask

  // Stream lookup from the bench's own copy of palette A.
  task automatic look_a(input logic [2:0] idx);
    logic [23:0] e;
    e = tbl_a[idx];
    drive_a(idx, 1'b1, 1'b0, 2'd0, 1'b0, 3'd0, 24'h0, e[7:0], e[15:8], e[23:16]);
  endtask

  initial begin
    logic [3:0]  idx, wa;
    logic        wen, bl;
    logic [1:0]  d;
    logic [29:0] wd, ent;
    logic [9:0]  er, eg, eb;
    logic [23:0] t;

    rst = 1'b1;
    bus_a.pix_idx = '0; bus_a.pix_valid = 1'b0; bus_a.blank = 1'b0; bus_a.dim = '0;
    bus_a.wr_en = 1'b0; bus_a.wr_addr = '0; bus_a.wr_data = '0;
    bus_b.pix_idx = '0; bus_b.pix_valid = 1'b0; bus_b.blank = 1'b0; bus_b.dim = '0;
    bus_b.wr_en = 1'b0; bus_b.wr_addr = '0; bus_b.wr_data = '0;
    foreach (tbl_a[i]) tbl_a[i] = def_tbl[i];

    // Write strobe held through reset must be ignored.
    @(negedge clk);
    bus_a.pix_valid = 1'b1; bus_a.pix_idx = 3'd7;
    bus_a.wr_en = 1'b1; bus_a.wr_addr = 3'd5; bus_a.wr_data = 24'hffffff;
    repeat (3) @(negedge clk);
    check("rst_a_r", 32'(bus_a.vga_r), 32'd0);
    check("rst_a_valid", 32'(bus_a.valid_out), 32'd0);
    check("rst_a_blank", 32'(bus_a.blank_out), 32'd0);
    check("rst_b_b", 32'(bus_b.vga_b), 32'd0);
    check("rst_b_valid", 32'(bus_b.valid_out), 32'd0);
    bus_a.wr_en = 1'b0; bus_a.pix_valid = 1'b0;
    rst = 1'b0;

    // Defaults, dimming, blanking.
    drive_a(3'd2, 1'b1, 1'b0, 2'd0, 1'b0, 3'd0, 24'h0, 8'h46, 8'h0a, 8'h0a);
    drive_a(3'd7, 1'b1, 1'b0, 2'd0, 1'b0, 3'd0, 24'h0, 8'h57, 8'h5f, 8'h64);
    drive_a(3'd7, 1'b1, 1'b0, 2'd1, 1'b0, 3'd0, 24'h0, 8'h2b, 8'h2f, 8'h32);
    drive_a(3'd7, 1'b1, 1'b0, 2'd3, 1'b0, 3'd0, 24'h0, 8'h0a, 8'h0b, 8'h0c);
    drive_a(3'd7, 1'b1, 1'b1, 2'd2, 1'b0, 3'd0, 24'h0, 8'h00, 8'h00, 8'h00);
    drive_a(3'd7, 1'b1, 1'b0, 2'd0, 1'b0, 3'd0, 24'h0, 8'h57, 8'h5f, 8'h64);
    drive_a(3'd5, 1'b1, 1'b0, 2'd0, 1'b0, 3'd0, 24'h0, 8'h00, 8'h00, 8'h00);

    // Write-first bypass, persistence, write elsewhere during a lookup.
    drive_a(3'd3, 1'b1, 1'b0, 2'd0, 1'b1, 3'd3, 24'h123456, 8'h56, 8'h34, 8'h12);
    drive_a(3'd3, 1'b1, 1'b0, 2'd0, 1'b0, 3'd0, 24'h0, 8'h56, 8'h34, 8'h12);
    drive_a(3'd4, 1'b1, 1'b0, 2'd0, 1'b1, 3'd6, 24'habcdef, 8'h21, 8'h26, 8'h2d);
    drive_a(3'd0, 1'b0, 1'b0, 2'd0, 1'b0, 3'd0, 24'h0, 8'h00, 8'h00, 8'h00);
    drive_a(3'd6, 1'b1, 1'b0, 2'd0, 1'b0, 3'd0, 24'h0, 8'hef, 8'hcd, 8'hab);
    tbl_a[3] = 24'h123456; tbl_a[6] = 24'habcdef;
    idle(3);

    // Reset mid-stream: in-flight pixels are lost, outputs clear at once.
    for (int i = 0; i < 5; i++) look_a(3'(i));
    @(posedge clk);
    #2;
    check("pre_rst_valid", 32'(bus_a.valid_out), 32'd1);
    rst = 1'b1;
    q_a.delete();
    bus_a.pix_valid = 1'b0;
    #1;
    check("mid_rst_r", 32'(bus_a.vga_r), 32'd0);
    check("mid_rst_g", 32'(bus_a.vga_g), 32'd0);
    check("mid_rst_b", 32'(bus_a.vga_b), 32'd0);
    check("mid_rst_valid", 32'(bus_a.valid_out), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    foreach (tbl_a[i]) tbl_a[i] = def_tbl[i];
    @(negedge clk);
    check("post_rst_valid", 32'(bus_a.valid_out), 32'd0);
    look_a(3'd3);
    look_a(3'd6);
    idle(3);

    // Wider instance: entries beyond the default table, left alignment, random traffic.
    foreach (mdl_b[i]) begin
      if (i < 8) begin
        t = def_tbl[i];
        mdl_b[i] = {t[23:16], 2'b00, t[15:8], 2'b00, t[7:0], 2'b00};
      end else mdl_b[i] = '0;
    end
    drive_b(4'd12, 1'b0, 2'd0, 1'b0, 4'd0, 30'h0, 10'h000, 10'h000, 10'h000);
    drive_b(4'd7, 1'b0, 2'd0, 1'b0, 4'd0, 30'h0, 10'h15c, 10'h17c, 10'h190);
    for (int n = 0; n < 40; n++) begin
      idx = 4'($urandom_range(0, 15));
      wa  = (n % 3 == 0) ? idx : 4'($urandom_range(0, 15));
      wen = 1'($urandom_range(0, 1));
      wd  = 30'($urandom());
      d   = 2'($urandom_range(0, 3));
      bl  = ($urandom_range(0, 7) == 0);
      ent = (wen && wa == idx) ? wd : mdl_b[idx];
      er  = bl ? 10'h0 : ent[9:0]   >> d;
      eg  = bl ? 10'h0 : ent[19:10] >> d;
      eb  = bl ? 10'h0 : ent[29:20] >> d;
      drive_b(idx, bl, d, wen, wa, wd, er, eg, eb);
      if (wen) mdl_b[wa] = wd;
    end

    // Bounded drain: anything left queued was never presented.
    for (int n = 0; n < 10 && (q_a.size() != 0 || q_b.size() != 0); n++) idle(1);
    idle(1);
    check("a_drained", 32'(q_a.size()), 32'd0);
    check("b_drained", 32'(q_b.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
